// File: rtl/aes_inv_stages.sv
// aes_inv_stages: one AES inverse-cipher round as a multi-cycle FSM; define AES_INV_SBOX_FULL_EN for 16 parallel inverse S-boxes.
module aes_inv_stages (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [127:0] round_state_i,
  input  logic [127:0] round_key_i,
  input  logic         en_i,
  input  logic         hold_i,
  input  logic         zero_round_i,
  input  logic         final_round_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] round_state_o
);
  typedef enum logic [2:0] {IDLE, INV_SHIFTROW, INV_SUBBYTE, ADDROUNDKEY, INV_MIXCOLUMN, DONE} state_t;
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  state_t       fsm;
  logic [1:0]   col;
  logic [127:0] st, key, shifted, subbed, mixed;
  logic         zero_q, final_q;
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b111} -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] v [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      v[i]  = a[31-8*i -: 8];
      x2    = xt(v[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ v[i];
      mb[i] = x8 ^ x2 ^ v[i];
      md[i] = x8 ^ x4 ^ v[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
  end
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = inv_mix_col(st[127-32*c -: 32]);
  end
  // InvShiftRows is only wiring, so the S-box pass in INV_SHIFTROW works on the shifted view.
`ifdef AES_INV_SBOX_FULL_EN
  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++)
      subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
  end
`else
  logic [127:0] src;
  always_comb begin
    src    = fsm == INV_SHIFTROW ? shifted : st;
    subbed = src;
    for (int r = 0; r < 4; r++)
      subbed[127-8*(4*col+r) -: 8] = inv_sbox(src[127-8*(4*col+r) -: 8]);
  end
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      fsm           <= IDLE;
      col           <= '0;
      st            <= '0;
      key           <= '0;
      zero_q        <= 1'b0;
      final_q       <= 1'b0;
      round_state_o <= '0;
    end else if (hold_i) begin
      case (fsm)
        IDLE: if (en_i) begin
          st      <= round_state_i;
          key     <= round_key_i;
          zero_q  <= zero_round_i;
          final_q <= final_round_i;
          col     <= '0;
          fsm     <= zero_round_i ? ADDROUNDKEY : INV_SHIFTROW;
        end
        INV_SHIFTROW: begin
          st  <= subbed;
          col <= col + 2'd1;
`ifdef AES_INV_SBOX_FULL_EN
          fsm <= ADDROUNDKEY;
`else
          fsm <= INV_SUBBYTE;
`endif
        end
        INV_SUBBYTE: begin
          st  <= subbed;
          col <= col + 2'd1;
          fsm <= col == 2'd3 ? ADDROUNDKEY : INV_SUBBYTE;
        end
        ADDROUNDKEY: begin
          st <= st ^ key;
          if (zero_q || final_q) begin
            round_state_o <= st ^ key;
            fsm           <= DONE;
          end else fsm <= INV_MIXCOLUMN;
        end
        INV_MIXCOLUMN: begin
          st            <= mixed;
          round_state_o <= mixed;
          fsm           <= DONE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
  assign busy_o = fsm != IDLE;
  assign done_o = fsm == DONE;
endmodule

// File: doc/aes_inv_stages.md
AES_INV_STAGES -- requirements
Module: aes_inv_stages

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 round_state_i  input  128  ciphertext or intermediate state; [127:120]=byte0 (row0,col0), column-major per FIPS-197.
REQ-005 round_key_i  input  128  round key for this round, same byte order.
REQ-006 en_i  input  1  start request; sampled in IDLE only.
REQ-007 hold_i  input  1  active-high run; 0 freezes FSM, counter and datapath registers.
REQ-008 zero_round_i  input  1  initial round: AddRoundKey only.
REQ-009 final_round_i  input  1  last round: InvMixColumns skipped.
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 done_o  output  1  high exactly while FSM is in DONE.
REQ-012 round_state_o  output  128  registered round result.

Function
REQ-013 States SHALL be IDLE, INV_SHIFTROW, INV_SUBBYTE, ADDROUNDKEY, INV_MIXCOLUMN, DONE.
REQ-014 In IDLE with en_i=1 and hold_i=1, the block SHALL latch round_state_i, round_key_i, zero_round_i and final_round_i; next state ADDROUNDKEY if zero_round_i, else INV_SHIFTROW.
REQ-015 If zero_round_i and final_round_i are both high, zero_round_i SHALL take priority.
REQ-016 INV_SHIFTROW SHALL rotate row r right by r bytes in one cycle, then go to INV_SUBBYTE.
REQ-017 INV_SUBBYTE SHALL apply the inverse S-box to one column (4 bytes) per cycle, col0 first, using a 2-bit column counter; leave to ADDROUNDKEY after col3.
REQ-018 ADDROUNDKEY SHALL XOR the state with the latched key in one cycle; next INV_MIXCOLUMN unless the latched final flag or zero flag is set, then DONE.
REQ-019 INV_MIXCOLUMN SHALL multiply every column by the inverse matrix {0e,0b,0d,09} over GF(2^8) mod x^8+x^4+x^3+x+1 in one cycle, then go to DONE.
REQ-020 round_state_o SHALL load the working state on the edge entering DONE and hold it until the next entry to DONE.
REQ-021 DONE SHALL last one cycle (hold_i=1) and then return to IDLE; a new en_i is accepted no earlier than the following IDLE cycle.
REQ-022 Latency from accepting edge to first done_o cycle SHALL be: normal 7, final 6, zero 2 cycles.
REQ-023 en_i while busy_o=1 SHALL be ignored; round_state_i and round_key_i changes after acceptance SHALL not affect the result.
REQ-024 With hold_i=0, all registers SHALL hold; done_o stays high if frozen in DONE.

Reset
REQ-025 With rst_n=0 at a clock edge: FSM to IDLE, column counter 0, round_state_o 0, done_o 0, busy_o 0, latched flags 0; this applies regardless of hold_i.
REQ-026 Reset mid-operation SHALL abort the round with no done_o pulse; round_state_o stays 0 until the next completed round.

Configuration
REQ-027 Macro AES_INV_SBOX_FULL_EN SHALL select the InvSubBytes implementation.
REQ-028 Defined: 16 parallel inverse S-boxes, INV_SUBBYTE lasts 1 cycle, latencies normal 4, final 3, zero 2.
REQ-029 Undefined: 4 inverse S-boxes, column-serial, latencies per REQ-022; results identical in both builds.

Verification
REQ-030 Zero round: state 69c4e0d86a7b0430d8cdb78070b4c55a, key 13111d7fe3944a17f307a78b4d2b30c5, zero=1 -> round_state_o 7ad5fda789ef4e272bca100b3d9ff59f, done_o 2 cycles after accept.
REQ-031 Normal round: state 7ad5fda789ef4e272bca100b3d9ff59f, key 549932d1f08557681093ed9cbe2c974e -> round_state_o 54d990a16ba09ab596bbf40ea111702f, done_o after 7 (4 with macro) cycles.
REQ-032 Final round: state 6353e08c0960e104cd70b751bacad0e7, key 000102030405060708090a0b0c0d0e0f, final=1 -> round_state_o 00112233445566778899aabbccddeeff, done_o after 6 (3) cycles.
REQ-033 hold_i=0 for 3 cycles in INV_SUBBYTE during REQ-031 -> same result, done_o 3 cycles later; en_i pulses while busy ignored.
REQ-034 rst_n=0 for one cycle while in ADDROUNDKEY -> next cycle IDLE, busy_o=0, round_state_o=0, no done_o pulse.
